si53xx_config_sequencer: RTL and testbench
==========================================

Name: si53xx_config_sequencer

Overview:
- Upstream feeder for si53xx_spi_interface.
- On `start`, walks a synchronous register-map ROM of {page, reg, data} entries and issues one SPI write per entry. A page-register (0x01) write is inserted whenever the page changes.
- Honours a delay marker, used for the Si5396A post-preamble 300 ms wait, and reports busy/done/error to the board-control logic.

Parameters:
- ROM_AW, 9, ROM address width.
- NUM_ENTRIES, 400, number of valid ROM entries (1..2**ROM_AW).
- DELAY_CYCLES, 30000000, clk cycles per delay marker (300 ms at 100 MHz).
- PAGE_REG, 8'h01, device page register address.
- DELAY_PAGE, 8'hFF, page value that marks an entry as a delay.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sequence when idle
- rom_addr  out  ROM_AW  ROM read address
- rom_data  in  24  entry {page[23:16], reg[15:8], data[7:0]}, valid 1 cycle after rom_addr
- spi_ready  in  1  SPI interface idle and able to accept a command
- write  out  1  one-cycle write strobe to SPI interface
- read  out  1  one-cycle read strobe (verify feature only)
- rw_addr  out  8  SPI register address
- write_data  out  8  SPI write data
- read_data  in  8  SPI read result, valid when spi_ready returns high after a read
- busy  out  1  sequence in progress
- done  out  1  sticky; sequence completed
- error  out  1  sticky; verify mismatch or start while busy

Behaviour:
- Reset (async, active-high): all outputs 0, including rom_addr; FSM to IDLE; cached page invalid.
- States:
  - IDLE: on start -> FETCH; index=0, busy=1, done=0, error=0.
  - FETCH: drive rom_addr=index; 1 wait cycle -> DECODE.
  - DECODE:
    - page==DELAY_PAGE -> DELAY.
    - else page!=cached page or cache invalid -> PAGE_WR.
    - else -> DATA_WR.
  - PAGE_WR: wait for spi_ready=1, then pulse write 1 cycle with rw_addr=PAGE_REG, write_data=page; cache page -> PAGE_WAIT.
  - PAGE_WAIT: wait for spi_ready to fall, then rise -> DATA_WR.
  - DATA_WR: wait for spi_ready=1, then pulse write with rw_addr=reg, write_data=data -> DATA_WAIT.
  - DATA_WAIT: wait for spi_ready fall then rise -> NEXT (or VERIFY_RD when the feature is enabled).
  - DELAY: count DELAY_CYCLES-1 down to 0 -> NEXT; no SPI activity; cached page unchanged.
  - NEXT: index==NUM_ENTRIES-1 -> DONE; else index+1 -> FETCH.
  - DONE: busy=0, done=1 for 1 cycle in this state -> IDLE; done stays high until the next start.
- Handshake rules:
  - write/read are never asserted while spi_ready=0.
  - At most one strobe per command; strobes are exactly one cycle.
  - rw_addr/write_data are stable from the strobe until spi_ready re-rises.
- start while busy: ignored for sequencing; sets error=1.
- start in DONE cycle: ignored.
- Reset mid-sequence: immediate abort. Strobes drop asynchronously. The next start restarts from index 0 with page cache invalid, so the page is rewritten.
- rom_addr width: index saturates at NUM_ENTRIES-1; it never wraps.
- Latency per non-delay entry, ideal SPI: page-change entry = 2 SPI transactions; same-page entry = 1.

Optional Feature:
- Macro: SI53XX_VERIFY_EN.
- Defined:
  - After DATA_WAIT -> VERIFY_RD: pulse read with rw_addr=reg -> VERIFY_WAIT (fall then rise).
  - Compare read_data to data. Mismatch sets error=1; the sequence continues.
  - Page/delay entries are not verified.
- Undefined: read tied 0; VERIFY states absent; read_data ignored.

Decomposition:
- Shared package si53xx_pkg:
  - entry field slice constants (PAGE_MSB/LSB, REG_MSB/LSB, DATA_MSB/LSB).
  - PAGE_REG and DELAY_PAGE defaults.
  - FSM state encoding typedef.
- One natural sub-module: si53xx_delay_counter (load/count/expired pulse), reused by the SPI block's CS-guard timing.

Test Plan:
- Three entries {00,0B,68},{00,0C,02},{01,02,AA}, ideal SPI model:
  - writes observed: (01,00),(0B,68),(0C,02),(01,01),(02,AA).
  - done=1; exactly 5 write strobes.
- Entry {FF,00,00} between two page-0 writes, DELAY_CYCLES=50:
  - gap between writes ≥50 cycles with no strobes.
  - no page rewrite after the delay.
- spi_ready held low 200 cycles before the first command: no strobe until it rises; the strobe follows within 1 cycle.
- Reset asserted during DATA_WAIT of entry 2:
  - outputs 0 immediately.
  - new start re-issues (01,00) first.
- start pulsed while busy: error=1; sequence still completes, done=1.
- SI53XX_VERIFY_EN, model returns 8'h00 for reg 0C: error=1 after that entry; remaining entries still written.

Source files
------------

// File: rtl/si53xx_pkg.sv
// rtl/si53xx_pkg.sv - shared entry layout, defaults and FSM encoding for the si53xx config sequencer
// Build option: SI53XX_VERIFY_EN adds the readback states.
package si53xx_pkg;

  localparam int PAGE_MSB = 23;
  localparam int PAGE_LSB = 16;
  localparam int REG_MSB  = 15;
  localparam int REG_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam logic [7:0] PAGE_REG_DEF   = 8'h01;
  localparam logic [7:0] DELAY_PAGE_DEF = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PAGE_WR,
    S_PAGE_WAIT,
    S_DATA_WR,
    S_DATA_WAIT,
    S_DELAY,
    S_NEXT,
`ifdef SI53XX_VERIFY_EN
    S_VERIFY_RD,
    S_VERIFY_WAIT,
`endif
    S_DONE
  } seq_state_t;

  function automatic logic [7:0] entry_page(input logic [23:0] e);
    return e[PAGE_MSB:PAGE_LSB];
  endfunction

  function automatic logic [7:0] entry_reg(input logic [23:0] e);
    return e[REG_MSB:REG_LSB];
  endfunction

  function automatic logic [7:0] entry_data(input logic [23:0] e);
    return e[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/si53xx_config_sequencer_if.sv
// rtl/si53xx_config_sequencer_if.sv - ROM, SPI-command and status signals between the sequencer and its neighbours
interface si53xx_config_sequencer_if #(
  parameter int ROM_AW = 9
);
  logic              start;
  logic [ROM_AW-1:0] rom_addr;
  logic [23:0]       rom_data;
  logic              spi_ready;
  logic              write;
  logic              read;
  logic [7:0]        rw_addr;
  logic [7:0]        write_data;
  logic [7:0]        read_data;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  start, rom_data, spi_ready, read_data,
    output rom_addr, write, read, rw_addr, write_data, busy, done, error
  );

  modport slave (
    output start, rom_data, spi_ready, read_data,
    input  rom_addr, write, read, rw_addr, write_data, busy, done, error
  );
endinterface

// File: rtl/si53xx_delay_counter.sv
// rtl/si53xx_delay_counter.sv - loadable down-counter with a one-cycle expired pulse
// Expires load_val+1 cycles after the load cycle; also used for SPI CS-guard timing.
module si53xx_delay_counter #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;
  logic         r_active;
  logic         r_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_active  <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (i_load) begin
        r_cnt    <= i_load_val;
        r_active <= 1'b1;
      end else if (r_active) begin
        if (r_cnt == '0) begin
          r_active  <= 1'b0;
          r_expired <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/si53xx_config_sequencer.sv
// rtl/si53xx_config_sequencer.sv - walks a {page,reg,data} ROM and issues SPI writes, page switches and delays
// Build option: SI53XX_VERIFY_EN reads back each data write and flags mismatches.
module si53xx_config_sequencer
  import si53xx_pkg::*;
#(
  parameter int         ROM_AW       = 9,
  parameter int         NUM_ENTRIES  = 400,
  parameter int         DELAY_CYCLES = 30000000,
  parameter logic [7:0] PAGE_REG     = PAGE_REG_DEF,
  parameter logic [7:0] DELAY_PAGE   = DELAY_PAGE_DEF
) (
  input  logic clk,
  input  logic reset,
  si53xx_config_sequencer_if.master bus
);

  localparam int                DLY_W    = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [DLY_W-1:0]  DLY_LOAD = DLY_W'(DELAY_CYCLES - 1);
  localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(NUM_ENTRIES - 1);

  seq_state_t        r_state;
  logic [ROM_AW-1:0] r_index;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [23:0]       r_entry;
  logic [7:0]        r_page;
  logic              r_page_valid;
  logic              r_seen_low;
  logic              r_write;
  logic [7:0]        r_rw_addr;
  logic [7:0]        r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_dly_load;
  logic              w_dly_expired;
  logic [7:0]        w_page;
`ifdef SI53XX_VERIFY_EN
  logic              r_read;
`endif

  assign w_page = entry_page(bus.rom_data);

  si53xx_delay_counter #(.W(DLY_W)) u_delay (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_dly_load),
    .i_load_val (DLY_LOAD),
    .o_expired  (w_dly_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_rom_addr   <= '0;
      r_entry      <= '0;
      r_page       <= '0;
      r_page_valid <= 1'b0;
      r_seen_low   <= 1'b0;
      r_write      <= 1'b0;
      r_rw_addr    <= '0;
      r_wdata      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_dly_load   <= 1'b0;
`ifdef SI53XX_VERIFY_EN
      r_read       <= 1'b0;
`endif
    end else begin
      r_write    <= 1'b0;
      r_dly_load <= 1'b0;
`ifdef SI53XX_VERIFY_EN
      r_read     <= 1'b0;
`endif
      if (bus.start && r_busy)
        r_error <= 1'b1;

      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state      <= S_FETCH;
          r_index      <= '0;
          r_rom_addr   <= '0;
          r_busy       <= 1'b1;
          r_done       <= 1'b0;
          r_error      <= 1'b0;
          r_page_valid <= 1'b0;
        end
        // ROM address is already set on entry to FETCH, so data is ready in DECODE.
        S_FETCH: begin
          r_rom_addr <= r_index;
          r_state    <= S_DECODE;
        end
        S_DECODE: begin
          r_entry <= bus.rom_data;
          if (w_page == DELAY_PAGE) begin
            r_dly_load <= 1'b1;
            r_state    <= S_DELAY;
          end else if (!r_page_valid || (w_page != r_page)) begin
            r_state <= S_PAGE_WR;
          end else begin
            r_state <= S_DATA_WR;
          end
        end
        S_PAGE_WR: if (bus.spi_ready) begin
          r_write      <= 1'b1;
          r_rw_addr    <= PAGE_REG;
          r_wdata      <= entry_page(r_entry);
          r_page       <= entry_page(r_entry);
          r_page_valid <= 1'b1;
          r_seen_low   <= 1'b0;
          r_state      <= S_PAGE_WAIT;
        end
        S_PAGE_WAIT: begin
          if (!bus.spi_ready)
            r_seen_low <= 1'b1;
          else if (r_seen_low)
            r_state <= S_DATA_WR;
        end
        S_DATA_WR: if (bus.spi_ready) begin
          r_write    <= 1'b1;
          r_rw_addr  <= entry_reg(r_entry);
          r_wdata    <= entry_data(r_entry);
          r_seen_low <= 1'b0;
          r_state    <= S_DATA_WAIT;
        end
        S_DATA_WAIT: begin
          if (!bus.spi_ready)
            r_seen_low <= 1'b1;
          else if (r_seen_low)
`ifdef SI53XX_VERIFY_EN
            r_state <= S_VERIFY_RD;
`else
            r_state <= S_NEXT;
`endif
        end
`ifdef SI53XX_VERIFY_EN
        S_VERIFY_RD: if (bus.spi_ready) begin
          r_read     <= 1'b1;
          r_rw_addr  <= entry_reg(r_entry);
          r_seen_low <= 1'b0;
          r_state    <= S_VERIFY_WAIT;
        end
        S_VERIFY_WAIT: begin
          if (!bus.spi_ready) begin
            r_seen_low <= 1'b1;
          end else if (r_seen_low) begin
            if (bus.read_data != entry_data(r_entry))
              r_error <= 1'b1;
            r_state <= S_NEXT;
          end
        end
`endif
        S_DELAY: if (w_dly_expired) r_state <= S_NEXT;
        S_NEXT: begin
          if (r_index == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_index    <= r_index + 1'b1;
            r_rom_addr <= r_index + 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.write      = r_write;
  assign bus.rw_addr    = r_rw_addr;
  assign bus.write_data = r_wdata;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
`ifdef SI53XX_VERIFY_EN
  assign bus.read       = r_read;
`else
  assign bus.read       = 1'b0;
`endif

endmodule

// File: tb/tb_si53xx_config_sequencer.sv
// tb/tb_si53xx_config_sequencer.sv - scoreboard bench: ROM + SPI models, write-order, delay, reset and error checks
module tb_si53xx_config_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  si53xx_config_sequencer_if #(.ROM_AW(9)) bus();

  si53xx_config_sequencer #(
    .ROM_AW(9), .NUM_ENTRIES(6), .DELAY_CYCLES(50), .PAGE_REG(8'h01), .DELAY_PAGE(8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef SI53XX_VERIFY_EN
  localparam logic [31:0] EXP_ERR = 1;
  localparam int          EXP_RD  = 5;
`else
  localparam logic [31:0] EXP_ERR = 0;
  localparam int          EXP_RD  = 0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         min_gap;
  } exp_t;

  logic [23:0] rom  [0:511];
  logic [7:0]  regs [0:255];
  logic        hold_low;
  int          spi_cnt = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_wr = 0;
  int          n_rd = 0;
  int          last_wr_cyc = 0;
  logic        prev_wr = 1'b0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // SPI model: drops ready after a strobe, busy 3 cycles, register file for readback (0x0C reads as 0).
  always @(posedge clk) begin
    if (spi_cnt > 0) begin
      spi_cnt <= spi_cnt - 1;
      if (spi_cnt == 1) bus.spi_ready <= !hold_low;
    end else if (bus.write === 1'b1) begin
      regs[bus.rw_addr] <= bus.write_data;
      bus.spi_ready     <= 1'b0;
      spi_cnt           <= 3;
    end else if (bus.read === 1'b1) begin
      bus.read_data <= (bus.rw_addr == 8'h0C) ? 8'h00 : regs[bus.rw_addr];
      bus.spi_ready <= 1'b0;
      spi_cnt       <= 3;
    end else begin
      bus.spi_ready <= !hold_low;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!reset && bus.write === 1'b1) begin
      n_wr++;
      check(bus.spi_ready === 1'b1, "write_needs_ready", 32'(bus.spi_ready), 1);
      check(!prev_wr, "write_one_cycle", 32'(prev_wr), 0);
      check(exp_q.size() > 0, "write_expected", {bus.rw_addr, bus.write_data}, 0);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check({bus.rw_addr, bus.write_data} === {mon_e.a, mon_e.d}, "write_pair",
              {bus.rw_addr, bus.write_data}, {mon_e.a, mon_e.d});
        if (mon_e.min_gap > 0)
          check(cyc - last_wr_cyc >= mon_e.min_gap, "delay_gap", cyc - last_wr_cyc, mon_e.min_gap);
      end
      last_wr_cyc = cyc;
    end
    if (!reset && bus.read === 1'b1) begin
      n_rd++;
      check(bus.spi_ready === 1'b1, "read_needs_ready", 32'(bus.spi_ready), 1);
    end
    prev_wr = (bus.write === 1'b1);
  end

  task automatic push(input logic [7:0] a, input logic [7:0] d, input int g);
    exp_t e;
    e.a = a; e.d = d; e.min_gap = g;
    exp_q.push_back(e);
  endtask

  task automatic push_all();
    push(8'h01, 8'h00, 0);
    push(8'h0B, 8'h68, 0);
    push(8'h0C, 8'h02, 0);
    push(8'h01, 8'h01, 0);
    push(8'h02, 8'hAA, 0);
    push(8'h01, 8'h00, 0);
    push(8'h10, 8'h11, 0);
    push(8'h11, 8'h22, 50);
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (bus.done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(bus.done === 1'b1, name, 32'(bus.done), 1);
  endtask

  task automatic check_zero(input string name);
    check({bus.write, bus.read, bus.busy, bus.done, bus.error} === 5'b0, name,
          32'({bus.write, bus.read, bus.busy, bus.done, bus.error}), 0);
    check(bus.rom_addr === 9'd0, {name, "_rom_addr"}, 32'(bus.rom_addr), 0);
    check({bus.rw_addr, bus.write_data} === 16'h0, {name, "_rw"}, {bus.rw_addr, bus.write_data}, 0);
  endtask

  initial begin
    int k;
    int w0;
    bus.start = 1'b0;
    hold_low  = 1'b1;
    for (int i = 0; i < 512; i++) rom[i] = 24'h0;
    rom[0] = 24'h000B68;
    rom[1] = 24'h000C02;
    rom[2] = 24'h0102AA;
    rom[3] = 24'h001011;
    rom[4] = 24'hFF0000;
    rom[5] = 24'h001122;

    repeat (3) @(negedge clk);
    check_zero("reset_state");
    @(negedge clk) reset = 1'b0;

    // Sequence with SPI held not-ready for 200 cycles before the first command.
    push_all();
    pulse_start();
    check(bus.busy === 1'b1, "busy_after_start", 32'(bus.busy), 1);
    repeat (200) @(negedge clk);
    check(n_wr == 0, "no_write_while_not_ready", n_wr, 0);
    hold_low = 1'b0;
    k = 0;
    while (bus.spi_ready !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    k = 0;
    while (bus.write !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    check(k == 1, "strobe_after_ready", k, 1);
    wait_done("t1_done");
    check(bus.busy === 1'b0, "t1_busy_clear", 32'(bus.busy), 0);
    check(bus.error === EXP_ERR[0], "t1_error", 32'(bus.error), EXP_ERR);
    check(n_wr == 8, "t1_write_count", n_wr, 8);
    check(n_rd == EXP_RD, "t1_read_count", n_rd, EXP_RD);
    repeat (5) @(negedge clk);
    check(bus.done === 1'b1, "done_sticky", 32'(bus.done), 1);
    check(exp_q.size() == 0, "t1_drained", exp_q.size(), 0);

    // Reset during DATA_WAIT of entry 2, then a clean restart.
    push_all();
    pulse_start();
    check(bus.done === 1'b0, "done_cleared_on_start", 32'(bus.done), 0);
    k = 0;
    while (!(bus.write === 1'b1 && bus.rw_addr == 8'h0C) && k < 500) begin @(negedge clk); k++; end
    check(k < 500, "reached_entry2", k, 500);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("reset_abort");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    w0 = n_wr;
    push_all();
    pulse_start();
    wait_done("t2_done");
    check(bus.error === EXP_ERR[0], "t2_error", 32'(bus.error), EXP_ERR);
    check(n_wr - w0 == 8, "t2_write_count", n_wr - w0, 8);
    repeat (5) @(negedge clk);
    check(exp_q.size() == 0, "t2_drained", exp_q.size(), 0);

    // Start while busy: flagged, but the sequence carries on unchanged.
    w0 = n_wr;
    push_all();
    pulse_start();
    repeat (20) @(negedge clk);
    check(bus.busy === 1'b1, "t3_busy", 32'(bus.busy), 1);
    pulse_start();
    check(bus.error === 1'b1, "error_on_busy_start", 32'(bus.error), 1);
    wait_done("t3_done");
    check(bus.error === 1'b1, "t3_error_sticky", 32'(bus.error), 1);
    check(n_wr - w0 == 8, "t3_write_count", n_wr - w0, 8);
    repeat (5) @(negedge clk);
    check(exp_q.size() == 0, "t3_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
